// File: rtl/add_sched_pkg.sv
// Shared state encoding and round-robin helper for the serial-add scheduler.
package add_sched_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        ADD  = ST_ADD,
        DONE = ST_DONE
    } state_t;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/serial_add_core.sv
// LSB-first bit-serial adder: operand/result shift registers, carry and bit counter.
module serial_add_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum_next,
    output logic             carry_next,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             sum_bit;

    assign sum_bit    = a_sh[0] ^ b_sh[0] ^ carry;
    assign carry_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    // The new bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
    assign sum_next   = {sum_bit, sum_sh[WIDTH-1:1]};
    assign done       = shift && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else if (load) begin
            a_sh   <= a;
            b_sh   <= b;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else if (shift) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= sum_next;
            carry  <= carry_next;
            cnt    <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/serial_add_sched.sv
// Round-robin scheduler sharing one bit-serial adder among NREQ requesters.
// Handshakes: a transfer happens on a rising clk edge where valid and ready are both high.
module serial_add_sched
    import add_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout,
    output logic [IDW-1:0]        rsp_id,
    output logic                  busy,
    output state_t                state
);

    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   cur_id;
    logic [NREQ-1:0]  rot;
    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic             accept;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic [WIDTH-1:0] sum_next;
    logic             carry_next;
    logic             done;

    // Rotating by rr_ptr makes bit k of rot correspond to requester (rr_ptr+k) mod NREQ.
    always_comb begin
        int unsigned idx;
        idx         = 32'd0;
        rot         = NREQ'({req_valid, req_valid} >> rr_ptr);
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_found && rot[k]) begin
                grant_found = 1'b1;
                idx         = 32'(rr_ptr) + 32'(k);
                if (idx >= 32'(NREQ)) idx = idx - 32'(NREQ);
                grant_idx   = IDW'(idx);
            end
        end
    end

    assign accept    = (state == IDLE) && !rst && grant_found;
    assign req_ready = accept ? (NREQ'(1) << grant_idx) : '0;
    assign a_sel     = req_a[grant_idx*WIDTH +: WIDTH];
    assign b_sel     = req_b[grant_idx*WIDTH +: WIDTH];
    assign busy      = (state != IDLE);

    serial_add_core #(.WIDTH(WIDTH)) u_core (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .shift      (state == ADD),
        .a          (a_sel),
        .b          (b_sel),
        .sum_next   (sum_next),
        .carry_next (carry_next),
        .done       (done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            cur_id    <= '0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cur_id <= grant_idx;
                        rr_ptr <= IDW'(rr_next(32'(grant_idx), NREQ));
                        state  <= ADD;
                    end
                end
                ADD: begin
                    if (done) begin
                        rsp_sum   <= sum_next;
                        rsp_cout  <= carry_next;
                        rsp_id    <= cur_id;
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sched.sv
// Directed bench for serial_add_sched: latency, overflow, fairness, backpressure, reset, drops.
module tb_serial_add_sched;
    import add_sched_pkg::*;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_cout;
    logic [IDW-1:0]        rsp_id;
    logic                  busy;
    state_t                state;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [IDW+WIDTH:0] exp_q[$];

    serial_add_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_id    (rsp_id),
        .busy      (busy),
        .state     (state)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // driver tasks
    task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_valid[i]             = 1'b1;
        req_a[i*WIDTH +: WIDTH]  = a;
        req_b[i*WIDTH +: WIDTH]  = b;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic finish_rsp();
        req_valid = '0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_rsp(input string name, input int n, input logic [WIDTH-1:0] sum,
                             input logic cout, input logic [IDW-1:0] id);
        checks++;
        if (n >= 40) begin
            failures++;
            $display("FAIL %s_timeout: got no rsp_valid expected rsp_valid", name);
        end
        checks++;
        if ({rsp_id, rsp_cout, rsp_sum} !== {id, cout, sum}) begin
            failures++;
            $display("FAIL %s_rsp: got id=%0d cout=%0b sum=%h expected id=%0d cout=%0b sum=%h",
                     name, rsp_id, rsp_cout, rsp_sum, id, cout, sum);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rsp_ready = 1'b1; req_valid = 4'b1111; req_a = '0; req_b = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id, busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got rdy=%b v=%b sum=%h c=%b id=%0d busy=%b expected all 0",
                     req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id, busy);
        end
        checks++;
        if (state !== IDLE) begin
            failures++;
            $display("FAIL reset_state: got %0d expected %0d", state, IDLE);
        end
        req_valid = '0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int n;
        set_req(0, 8'h3C, 8'h05);
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL single_grant: got %b expected 0001", req_ready);
        end
        wait_rsp(n);
        checks++;
        if (n !== 9) begin
            failures++;
            $display("FAIL single_latency: got %0d expected 9", n);
        end
        check_rsp("single", n, 8'h41, 1'b0, 2'd0);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL single_busy_done: got %b expected 1", busy);
        end
        finish_rsp();
        checks++;
        if ({rsp_valid, busy} !== 2'b00) begin
            failures++;
            $display("FAIL single_after: got v=%b busy=%b expected 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_overflow();
        int n;
        set_req(2, 8'hFF, 8'h02);
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL overflow_grant: got %b expected 0100", req_ready);
        end
        wait_rsp(n);
        check_rsp("overflow", n, 8'h01, 1'b1, 2'd2);
        finish_rsp();
    endtask

    task automatic test_backpressure();
        int n;
        rsp_ready = 1'b0;
        set_req(3, 8'h12, 8'h34);
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            failures++;
            $display("FAIL bp_grant: got %b expected 1000", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        set_req(1, 8'h05, 8'h06);
        wait_rsp(n);
        check_rsp("bp_first", n, 8'h46, 1'b0, 2'd3);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({rsp_valid, rsp_sum, rsp_id, req_ready} !== {1'b1, 8'h46, 2'd3, 4'b0000}) begin
                failures++;
                $display("FAIL bp_hold: got v=%b sum=%h id=%0d rdy=%b expected v=1 sum=46 id=3 rdy=0000",
                         rsp_valid, rsp_sum, rsp_id, req_ready);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({rsp_valid, req_ready} !== {1'b0, 4'b0010}) begin
            failures++;
            $display("FAIL bp_next_accept: got v=%b rdy=%b expected v=0 rdy=0010", rsp_valid, req_ready);
        end
        @(negedge clk);
        checks++;
        if (state !== ADD) begin
            failures++;
            $display("FAIL bp_in_add: got %0d expected %0d", state, ADD);
        end
        req_valid = '0;
        wait_rsp(n);
        check_rsp("bp_second", n, 8'h0B, 1'b0, 2'd1);
        finish_rsp();
    endtask

    task automatic test_mid_reset();
        int  n;
        logic seen;
        set_req(0, 8'h10, 8'h20);
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL mrst_grant: got %b expected 0001", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({state, busy, rsp_valid, req_ready, rsp_sum, rsp_cout, rsp_id} !== '0) begin
            failures++;
            $display("FAIL mrst_outputs: got st=%0d busy=%b v=%b rdy=%b sum=%h c=%b id=%0d expected all 0",
                     state, busy, rsp_valid, req_ready, rsp_sum, rsp_cout, rsp_id);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL mrst_no_rsp: got rsp_valid=1 expected 0");
        end
        set_req(3, 8'h01, 8'h01);
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            failures++;
            $display("FAIL mrst_grant3: got %b expected 1000", req_ready);
        end
        wait_rsp(n);
        check_rsp("mrst_after", n, 8'h02, 1'b0, 2'd3);
        finish_rsp();
    endtask

    task automatic test_fairness();
        logic [3:0]       exp_oh[5]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [IDW-1:0]   exp_id[5]  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [WIDTH-1:0] exp_sum[4] = '{8'h03, 8'h00, 8'h80, 8'hFF};
        logic             exp_c[4]   = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [IDW+WIDTH:0] e;
        int acc = 0, got = 0, last = 0;
        exp_q.delete();
        rsp_ready = 1'b1;
        set_req(0, 8'h01, 8'h02);
        set_req(1, 8'h80, 8'h80);
        set_req(2, 8'h7F, 8'h01);
        set_req(3, 8'hAA, 8'h55);
        for (int step = 0; step < 80 && got < 5; step++) begin
            #1;
            if (req_ready !== 4'b0000 && acc < 5) begin
                checks++;
                if (req_ready !== exp_oh[acc]) begin
                    failures++;
                    $display("FAIL fair_grant%0d: got %b expected %b", acc, req_ready, exp_oh[acc]);
                end
                if (acc > 0) begin
                    checks++;
                    if (cyc - last !== 10) begin
                        failures++;
                        $display("FAIL fair_interval%0d: got %0d expected 10", acc, cyc - last);
                    end
                end
                exp_q.push_back({exp_id[acc], exp_c[exp_id[acc]], exp_sum[exp_id[acc]]});
                last = cyc;
                acc++;
            end else if (acc == 5) begin
                req_valid = '0;
            end
            if (rsp_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL fair_unexpected: got id=%0d expected no response", rsp_id);
                end else begin
                    e = exp_q.pop_front();
                    if ({rsp_id, rsp_cout, rsp_sum} !== e) begin
                        failures++;
                        $display("FAIL fair_rsp%0d: got %h expected %h", got, {rsp_id, rsp_cout, rsp_sum}, e);
                    end
                end
                got++;
            end
            @(negedge clk);
        end
        checks++;
        if ({acc, got} !== {32'd5, 32'd5}) begin
            failures++;
            $display("FAIL fair_counts: got acc=%0d rsp=%0d expected 5 5", acc, got);
        end
        req_valid = '0;
    endtask

    task automatic test_dropped();
        int  n;
        logic bad;
        set_req(0, 8'h0F, 8'h01);
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL drop_grant: got %b expected 0001", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        req_valid[2] = 1'b1;
        @(negedge clk);
        req_valid[2] = 1'b0;
        wait_rsp(n);
        check_rsp("drop_served", n, 8'h10, 1'b0, 2'd0);
        finish_rsp();
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000) bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad !== 1'b0) begin
            failures++;
            $display("FAIL drop_never_granted: got activity expected idle");
        end
    endtask

    // sequence and final report
    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_overflow();
        test_backpressure();
        test_mid_reset();
        test_fairness();
        test_dropped();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
